// File: rtl/window_pkg.sv
// Shared definitions for the sliding-window generator: FSM encoding,
// default line-buffer addressing and the window bit-placement helper.
package window_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_IMG_W_DEFAULT = 64;
    localparam int AW                = $clog2(MAX_IMG_W_DEFAULT);

    // Bit offset of window element (r,c); r=0 is the oldest row, c=0 the left column.
    function automatic int win_bit(input int r, input int c, input int kw, input int bw);
        return (r * kw + c) * bw;
    endfunction

endpackage

// File: rtl/window_gen_if.sv
// Stream bundle between the feature-map source, the window generator and
// the MAC array. The slave side is the window generator.
interface window_gen_if #(
    parameter int IF_BW = 8,
    parameter int KW    = 3,
    parameter int KH    = 3,
    parameter int PIXEL = 4
);
    localparam int DWIDTH = PIXEL * IF_BW;
    localparam int FWIDTH = IF_BW * KH * KW;

    logic [DWIDTH-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [FWIDTH-1:0] m_fmap;
    logic              m_valid;
    logic              m_ready;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_fmap, m_valid
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_fmap, m_valid
    );

endinterface

// File: rtl/window_gen_line_buffer.sv
// One image-row delay line. The read port returns the value stored at addr
// before this cycle's write lands, so a read and a write at the same column
// in one cycle behave as read-before-write.
module line_buffer
    import window_pkg::*;
#(
    parameter int DEPTH  = MAX_IMG_W_DEFAULT,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Store the incoming pixel for the same column of the next row.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_gen.sv
// Sliding-window generator: unpacks PIXEL-wide beats to one pixel per cycle,
// keeps KH-1 previous rows in line buffers and emits a KHxKW window for each
// valid (unpadded) output position over a ready/valid stream.
module window_gen
    import window_pkg::*;
#(
    parameter int IF_BW     = 8,
    parameter int KW        = 3,
    parameter int KH        = 3,
    parameter int PIXEL     = 4,
    parameter int DWIDTH    = PIXEL * IF_BW,
    parameter int MAX_IMG_W = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_run,
    input  logic [$clog2(MAX_IMG_W+1)-1:0]   i_img_w,
    input  logic [15:0]                      i_img_h,
    window_gen_if.slave                      bus,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int WW  = $clog2(MAX_IMG_W + 1);
    localparam int CAW = $clog2(MAX_IMG_W);
    localparam int TW  = WW + 16;
    localparam int LW  = (PIXEL > 1) ? $clog2(PIXEL) : 1;
    localparam int FW  = IF_BW * KH * KW;

    state_t             state_r;
    state_t             state_nx;
    logic [WW-1:0]      img_w_r;
    logic [TW-1:0]      total_pix_r;
    logic [TW-1:0]      in_pix_r;
    logic [TW-1:0]      adv_cnt_r;
    logic [CAW-1:0]     col_r;
    logic [15:0]        row_r;
    logic [DWIDTH-1:0]  beat_r;
    logic [LW-1:0]      lane_r;
    logic               full_r;
    logic               m_valid_r;
    logic [IF_BW-1:0]   win_r [KH][KW];

    logic               start_s;
    logic               pix_left_s;
    logic               in_left_s;
    logic               last_lane_s;
    logic               advance_s;
    logic               s_ready_s;
    logic               accept_s;
    logic               col_last_s;
    logic               win_pos_s;
    logic [IF_BW-1:0]   pix_s;
    logic [IF_BW-1:0]   lb_rd_s [KH-1];
    logic [IF_BW-1:0]   lb_wr_s [KH-1];
    logic [IF_BW-1:0]   tap_s   [KH];
    logic [FW-1:0]      fmap_s;

    assign start_s     = (state_r == IDLE) && i_run;
    assign pix_left_s  = (adv_cnt_r != total_pix_r);
    assign in_left_s   = (in_pix_r < total_pix_r);
    assign last_lane_s = (lane_r == LW'(PIXEL - 1));
    assign pix_s       = beat_r[int'(lane_r) * IF_BW +: IF_BW];
    assign col_last_s  = (WW'(col_r) == (img_w_r - WW'(1)));
    assign win_pos_s   = (row_r >= 16'(KH - 1)) && (col_r >= CAW'(KW - 1));
    assign accept_s    = bus.s_valid && s_ready_s;

    // Advance and input-ready decisions; s_ready depends on m_ready through the advance.
    always_comb begin
        advance_s = 1'b0;
        s_ready_s = 1'b0;
        if (state_r == RUN) begin
            advance_s = full_r && pix_left_s && (!m_valid_r || bus.m_ready);
            s_ready_s = in_left_s && (!full_r || (advance_s && last_lane_s));
        end else begin
            advance_s = 1'b0;
            s_ready_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next state: finish once every pixel has advanced and no window is pending.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (i_run) begin
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (!pix_left_s && (!m_valid_r || bus.m_ready)) begin
                    state_nx = DONE;
                end else begin
                    state_nx = RUN;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Frame dimensions, input/advance pixel counts and raster position.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_w_r     <= '0;
            total_pix_r <= '0;
            in_pix_r    <= '0;
            adv_cnt_r   <= '0;
            col_r       <= '0;
            row_r       <= '0;
        end else if (start_s) begin
            img_w_r     <= i_img_w;
            total_pix_r <= TW'(i_img_w) * TW'(i_img_h);
            in_pix_r    <= '0;
            adv_cnt_r   <= '0;
            col_r       <= '0;
            row_r       <= '0;
        end else begin
            if (accept_s) begin
                in_pix_r <= in_pix_r + TW'(PIXEL);
            end
            if (advance_s) begin
                adv_cnt_r <= adv_cnt_r + TW'(1);
                if (col_last_s) begin
                    col_r <= '0;
                    row_r <= row_r + 16'd1;
                end else begin
                    col_r <= col_r + CAW'(1);
                end
            end
        end
    end

    // Unpacker: a new beat restarts at lane 0, each advance consumes one lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r <= '0;
            lane_r <= '0;
            full_r <= 1'b0;
        end else if (start_s) begin
            lane_r <= '0;
            full_r <= 1'b0;
        end else if (accept_s) begin
            beat_r <= bus.s_data;
            lane_r <= '0;
            full_r <= 1'b1;
        end else if (advance_s) begin
            if (last_lane_s) begin
                lane_r <= '0;
                full_r <= 1'b0;
            end else begin
                lane_r <= lane_r + LW'(1);
            end
        end
    end

    // Line-buffer chain: the newest row enters the last buffer and ages toward buffer 0.
    for (genvar g = 0; g < KH - 1; g++) begin : g_lb
        if (g == KH - 2) begin : g_newest
            assign lb_wr_s[g] = pix_s;
        end else begin : g_older
            assign lb_wr_s[g] = lb_rd_s[g + 1];
        end

        line_buffer #(
            .DEPTH  (MAX_IMG_W),
            .WIDTH  (IF_BW),
            .ADDR_W (CAW)
        ) u_lb (
            .clk     (clk),
            .we      (advance_s),
            .addr    (col_r),
            .wr_data (lb_wr_s[g]),
            .rd_data (lb_rd_s[g])
        );
    end

    // Column taps entering the right edge of the window, oldest row first.
    always_comb begin
        tap_s[KH-1] = pix_s;
        for (int r = 0; r < KH - 1; r++) begin
            tap_s[r] = lb_rd_s[r];
        end
    end

    // Window shift register: shift left and load the taps into the right column.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < KH; r++) begin
                for (int c = 0; c < KW; c++) begin
                    win_r[r][c] <= '0;
                end
            end
        end else if (advance_s) begin
            for (int r = 0; r < KH; r++) begin
                for (int c = 0; c < KW - 1; c++) begin
                    win_r[r][c] <= win_r[r][c + 1];
                end
                win_r[r][KW-1] <= tap_s[r];
            end
        end
    end

    // Output valid: set by an advance at a full-window position, cleared by a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r <= 1'b0;
        end else if (start_s) begin
            m_valid_r <= 1'b0;
        end else if (advance_s && win_pos_s) begin
            m_valid_r <= 1'b1;
        end else if (bus.m_ready) begin
            m_valid_r <= 1'b0;
        end
    end

    // Pack the window registers into the flat output bus.
    always_comb begin
        fmap_s = '0;
        for (int r = 0; r < KH; r++) begin
            for (int c = 0; c < KW; c++) begin
                fmap_s[win_bit(r, c, KW, IF_BW) +: IF_BW] = win_r[r][c];
            end
        end
    end

    assign bus.m_fmap  = fmap_s;
    assign bus.m_valid = m_valid_r;
    assign bus.s_ready = s_ready_s;
    assign o_busy      = (state_r == RUN);
    assign o_done      = (state_r == DONE);

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen: reset state, 4x4 frames with and without
// output stalls, an 8x3 frame with input gaps, a mid-frame abort and an
// i_run pulse during RUN. Pixel value = base + raster index.
module tb_window_gen;
    import window_pkg::*;

    localparam int IF_BW     = 8;
    localparam int KW        = 3;
    localparam int KH        = 3;
    localparam int PIXEL     = 4;
    localparam int MAX_IMG_W = 64;
    localparam int FW        = IF_BW * KH * KW;
    localparam int DW        = PIXEL * IF_BW;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_run;
    logic [6:0]  i_img_w;
    logic [15:0] i_img_h;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_fail   = 0;

    window_gen_if #(.IF_BW(IF_BW), .KW(KW), .KH(KH), .PIXEL(PIXEL)) bus ();

    window_gen #(
        .IF_BW(IF_BW), .KW(KW), .KH(KH), .PIXEL(PIXEL),
        .DWIDTH(DW), .MAX_IMG_W(MAX_IMG_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_run   (i_run),
        .i_img_w (i_img_w),
        .i_img_h (i_img_h),
        .bus     (bus),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] exp_win(input int w, input int base, input int k);
        int ox;
        int oy;
        logic [FW-1:0] v;
        ox = k % (w - KW + 1);
        oy = k / (w - KW + 1);
        v  = '0;
        for (int r = 0; r < KH; r++) begin
            for (int c = 0; c < KW; c++) begin
                v[(r * KW + c) * IF_BW +: IF_BW] = 8'((oy + r) * w + ox + c + base);
            end
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] beat_data(input int base, input int j);
        logic [DW-1:0] d;
        for (int i = 0; i < PIXEL; i++) begin
            d[i * IF_BW +: IF_BW] = 8'(j * PIXEL + i + base);
        end
        return d;
    endfunction

    // One frame: gap = % chance of an idle input cycle, stall = cycles m_ready is
    // held low at the first window, mid_run = pulse i_run during RUN,
    // abort_beats = reset the DUT shortly after that many beats were taken.
    task automatic run_frame(input int w, input int h, input int base, input int gap,
                             input int stall, input bit mid_run, input int abort_beats);
        int nbeats;
        int nwin;
        int wins;
        int dones;
        int beat;
        int held_cnt;
        int post;
        bit finished;
        logic [FW-1:0] held;
        nbeats   = (w * h) / PIXEL;
        nwin     = (w - KW + 1) * (h - KH + 1);
        wins     = 0;
        dones    = 0;
        beat     = 0;
        held_cnt = 0;
        post     = 0;
        finished = 1'b0;
        held     = '0;

        @(posedge clk); #1;
        i_img_w = 7'(w);
        i_img_h = 16'(h);
        i_run   = 1'b1;
        @(posedge clk); #1;
        i_run   = 1'b0;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            bus.s_valid = (beat < nbeats) && ($urandom_range(99) >= gap);
            bus.s_data  = beat_data(base, (beat < nbeats) ? beat : 0);
            bus.m_ready = !(stall > 0 && held_cnt < stall);
            if (mid_run && cyc == 6) begin
                i_img_w = 7'd8;
                i_img_h = 16'd8;
                i_run   = 1'b1;
            end else begin
                i_run   = 1'b0;
            end
            @(negedge clk);
            if (o_done) dones++;
            if (bus.s_valid && bus.s_ready) beat++;
            if (bus.m_valid && bus.m_ready) begin
                check_eq($sformatf("win%0d_%0dx%0d", wins, w, h), bus.m_fmap, exp_win(w, base, wins));
                if (w == 4 && h == 4 && base == 0 && wins == 0)
                    check_eq("first_win_const", bus.m_fmap, 72'h0a0908060504020100);
                if (w == 4 && h == 4 && base == 0 && wins == 3)
                    check_eq("last_win_const", bus.m_fmap, 72'h0f0e0d0b0a09070605);
                wins++;
            end
            if (stall > 0 && bus.m_valid && !bus.m_ready) begin
                if (held_cnt == 0) held = bus.m_fmap;
                else check_eq("stall_hold", bus.m_fmap, held);
                check_eq("stall_sready", 72'(bus.s_ready), 72'd0);
                held_cnt++;
            end
            if (abort_beats > 0 && beat >= abort_beats) begin
                post++;
                if (post == 3) finished = 1'b1;
            end
            if (dones > 0) begin
                post++;
                if (post == 4) finished = 1'b1;
            end
            @(posedge clk); #1;
        end

        check_eq("frame_end_reached", 72'(finished), 72'd1);
        if (abort_beats > 0) begin
            rst         = 1'b1;
            bus.s_valid = 1'b0;
            bus.m_ready = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            if (o_done) dones++;
            check_eq("abort_m_valid", 72'(bus.m_valid), 72'd0);
            check_eq("abort_busy", 72'(o_busy), 72'd0);
            check_eq("abort_fmap", bus.m_fmap, 72'd0);
            check_eq("abort_no_done", 72'(dones), 72'd0);
        end else begin
            check_eq($sformatf("win_count_%0dx%0d", w, h), 72'(wins), 72'(nwin));
            check_eq($sformatf("done_count_%0dx%0d", w, h), 72'(dones), 72'd1);
            check_eq("idle_sready", 72'(bus.s_ready), 72'd0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_run       = 1'b0;
        i_img_w     = 7'd0;
        i_img_h     = 16'd0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_m_valid", 72'(bus.m_valid), 72'd0);
        check_eq("rst_s_ready", 72'(bus.s_ready), 72'd0);
        check_eq("rst_o_done", 72'(o_done), 72'd0);
        check_eq("rst_o_busy", 72'(o_busy), 72'd0);
        check_eq("rst_m_fmap", bus.m_fmap, 72'd0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.s_valid = 1'b1;
            bus.s_data  = 32'hdeadbeef;
            @(negedge clk);
            check_eq("idle_no_accept", 72'(bus.s_ready), 72'd0);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;

        run_frame(4, 4, 0, 0, 0, 1'b0, 0);
        run_frame(4, 4, 0, 0, 5, 1'b0, 0);
        run_frame(8, 3, 0, 50, 0, 1'b0, 0);
        run_frame(4, 4, 0, 0, 0, 1'b0, 2);
        run_frame(4, 4, 100, 0, 0, 1'b0, 0);
        run_frame(4, 4, 0, 0, 0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
